// File: rtl/mem_arbiter_if.sv
// Core-side (IM/DM) and memory-side signals of the unified-memory arbiter.
// Names carry _i/_o relative to the arbiter; the slave modport is the arbiter's view.
interface mem_arbiter_if #(
  parameter int AW = 32,
  parameter int DW = 32
);
  logic          im_req_i;
  logic [AW-1:0] im_addr_i;
  logic [DW-1:0] im_dout_o;
  logic          im_busy_o;

  logic          dm_req_i;
  logic          dm_wen_i;
  logic [AW-1:0] dm_addr_i;
  logic [DW-1:0] dm_din_i;
  logic [DW-1:0] dm_dout_o;
  logic          dm_busy_o;

  logic          mem_en_o;
  logic          mem_wen_o;
  logic [AW-1:0] mem_addr_o;
  logic [DW-1:0] mem_din_o;
  logic [DW-1:0] mem_dout_i;

  modport slave (
    input  im_req_i, im_addr_i, dm_req_i, dm_wen_i, dm_addr_i, dm_din_i, mem_dout_i,
    output im_dout_o, im_busy_o, dm_dout_o, dm_busy_o,
           mem_en_o, mem_wen_o, mem_addr_o, mem_din_o
  );

  modport master (
    output im_req_i, im_addr_i, dm_req_i, dm_wen_i, dm_addr_i, dm_din_i, mem_dout_i,
    input  im_dout_o, im_busy_o, dm_dout_o, dm_busy_o,
           mem_en_o, mem_wen_o, mem_addr_o, mem_din_o
  );
endinterface

// File: rtl/mem_arbiter.sv
// Shares one single-port synchronous memory between fetch (IM) and data (DM) ports, one access at a time.
// DM has priority until it has been granted MAX_DM_STREAK times in a row over a waiting IM.
module mem_arbiter #(
  parameter int AW            = 32,
  parameter int DW            = 32,
  parameter int RD_LAT        = 1,
  parameter int MAX_DM_STREAK = 4
) (
  input  logic         clk_i,
  input  logic         rst_i,
  mem_arbiter_if.slave bus
);
  typedef enum logic [1:0] {S_IDLE = 2'd0, S_WAIT = 2'd1, S_DONE = 2'd2} state_e;

  localparam logic       OWN_IM     = 1'b0;
  localparam logic       OWN_DM     = 1'b1;
  localparam logic [2:0] LAT_INIT   = 3'(RD_LAT - 1);
  localparam logic [3:0] STREAK_MAX = 4'(MAX_DM_STREAK);

  state_e        state_q, state_d;
  logic          owner_q, owner_d;
  logic [2:0]    lat_cnt_q, lat_cnt_d;
  logic [3:0]    streak_q, streak_d;
  logic [DW-1:0] im_dout_q, im_dout_d;
  logic [DW-1:0] dm_dout_q, dm_dout_d;

  logic          grant_im, grant_dm;
  logic [AW-1:0] grant_addr;

  // Grant is gated by rst_i so the memory strobe drops as soon as reset asserts.
  always_comb begin
    grant_im = 1'b0;
    grant_dm = 1'b0;
    if (state_q == S_IDLE && !rst_i) begin
      if (bus.im_req_i && (!bus.dm_req_i || streak_q == STREAK_MAX)) begin
        grant_im = 1'b1;
      end else if (bus.dm_req_i) begin
        grant_dm = 1'b1;
      end
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      state_q   <= S_IDLE;
      owner_q   <= OWN_IM;
      lat_cnt_q <= '0;
      streak_q  <= '0;
      im_dout_q <= '0;
      dm_dout_q <= '0;
    end else begin
      state_q   <= state_d;
      owner_q   <= owner_d;
      lat_cnt_q <= lat_cnt_d;
      streak_q  <= streak_d;
      im_dout_q <= im_dout_d;
      dm_dout_q <= dm_dout_d;
    end
  end

  always_comb begin
    state_d   = state_q;
    owner_d   = owner_q;
    lat_cnt_d = lat_cnt_q;
    streak_d  = streak_q;
    im_dout_d = im_dout_q;
    dm_dout_d = dm_dout_q;
    case (state_q)
      S_IDLE: begin
        if (grant_im) begin
          owner_d   = OWN_IM;
          lat_cnt_d = LAT_INIT;
          streak_d  = '0;
          state_d   = S_WAIT;
        end else if (grant_dm) begin
          owner_d = OWN_DM;
          // Only a DM grant that makes IM wait counts toward starvation.
          if (bus.im_req_i && streak_q != STREAK_MAX) begin
            streak_d = streak_q + 4'd1;
          end
          if (bus.dm_wen_i) begin
            state_d = S_DONE;
          end else begin
            lat_cnt_d = LAT_INIT;
            state_d   = S_WAIT;
          end
        end
      end
      S_WAIT: begin
        if (lat_cnt_q != 3'd0) begin
          lat_cnt_d = lat_cnt_q - 3'd1;
        end else begin
          if (owner_q == OWN_DM) begin
            dm_dout_d = bus.mem_dout_i;
          end else begin
            im_dout_d = bus.mem_dout_i;
          end
          state_d = S_DONE;
        end
      end
      S_DONE:  state_d = S_IDLE;
      default: state_d = S_IDLE;
    endcase
  end

  always_comb begin
    grant_addr     = grant_dm ? bus.dm_addr_i : bus.im_addr_i;
    bus.mem_en_o   = grant_im | grant_dm;
    bus.mem_wen_o  = grant_dm & bus.dm_wen_i;
    bus.mem_addr_o = (grant_im | grant_dm) ? grant_addr : '0;
    bus.mem_din_o  = grant_dm ? bus.dm_din_i : '0;
    bus.im_busy_o  = bus.im_req_i & ~(state_q == S_DONE && owner_q == OWN_IM);
    bus.dm_busy_o  = bus.dm_req_i & ~(state_q == S_DONE && owner_q == OWN_DM);
    bus.im_dout_o  = im_dout_q;
    bus.dm_dout_o  = dm_dout_q;
  end
endmodule

// File: tb/tb_mem_arbiter.sv
// Directed bench: a per-cycle vector table on an RD_LAT=1 arbiter, then hand sequences
// on an RD_LAT=3 arbiter for long reads and asynchronous reset during WAIT.
`timescale 1ns/1ps
module tb_mem_arbiter;
  logic clk = 1'b0;
  logic rst1, rst3;
  always #5 clk = ~clk;

  mem_arbiter_if #(.AW(32), .DW(32)) if1 ();
  mem_arbiter_if #(.AW(32), .DW(32)) if3 ();

  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(1), .MAX_DM_STREAK(4)) u_dut1 (
    .clk_i(clk), .rst_i(rst1), .bus(if1.slave)
  );
  mem_arbiter #(.AW(32), .DW(32), .RD_LAT(3), .MAX_DM_STREAK(4)) u_dut3 (
    .clk_i(clk), .rst_i(rst3), .bus(if3.slave)
  );

  // f = {rst, im_req, dm_req, dm_wen}
  typedef struct packed {
    logic [3:0]  f;
    logic [31:0] im_addr, dm_addr, dm_din, mem_dout;
  } in_t;
  // f = {im_busy, dm_busy, mem_en, mem_wen}
  typedef struct packed {
    logic [3:0]  f;
    logic [31:0] mem_addr, mem_din, im_dout, dm_dout;
  } out_t;
  typedef struct {
    in_t  i;
    out_t o;
  } vec_t;

  vec_t vq[$];
  int   n_chk  = 0;
  int   n_fail = 0;

  task automatic add(input logic [3:0] fi, input logic [31:0] ia, input logic [31:0] da,
                     input logic [31:0] dd, input logic [31:0] md, input logic [3:0] fo,
                     input logic [31:0] ma, input logic [31:0] mdi, input logic [31:0] id,
                     input logic [31:0] dmd);
    vec_t v;
    v.i = '{f: fi, im_addr: ia, dm_addr: da, dm_din: dd, mem_dout: md};
    v.o = '{f: fo, mem_addr: ma, mem_din: mdi, im_dout: id, dm_dout: dmd};
    vq.push_back(v);
  endtask

  task automatic chk(input string name, input logic [135:0] act, input logic [135:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, act, exp);
    end
  endtask

  function automatic out_t sample1();
    out_t o;
    o.f        = {if1.im_busy_o, if1.dm_busy_o, if1.mem_en_o, if1.mem_wen_o};
    o.mem_addr = if1.mem_addr_o;
    o.mem_din  = if1.mem_din_o;
    o.im_dout  = if1.im_dout_o;
    o.dm_dout  = if1.dm_dout_o;
    return o;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    rst1 = 1'b1; rst3 = 1'b1;
    {if1.im_req_i, if1.dm_req_i, if1.dm_wen_i} = 3'b000;
    if1.im_addr_i = '0; if1.dm_addr_i = '0; if1.dm_din_i = '0; if1.mem_dout_i = '0;
    {if3.im_req_i, if3.dm_req_i, if3.dm_wen_i} = 3'b000;
    if3.im_addr_i = '0; if3.dm_addr_i = '0; if3.dm_din_i = '0; if3.mem_dout_i = '0;

    // reset: busy follows req, memory side quiet
    add(4'b1100, 32'h100, 32'h0, 32'h0, 32'h0,        4'b1000, 32'h0,    32'h0,  32'h0,        32'h0);
    add(4'b1000, 32'h0,   32'h0, 32'h0, 32'h0,        4'b0000, 32'h0,    32'h0,  32'h0,        32'h0);
    // single IM read, RD_LAT=1
    add(4'b0100, 32'h100, 32'h0, 32'h0, 32'h0,        4'b1010, 32'h100,  32'h0,  32'h0,        32'h0);
    add(4'b0100, 32'h100, 32'h0, 32'h0, 32'hDEADBEEF, 4'b1000, 32'h0,    32'h0,  32'h0,        32'h0);
    add(4'b0100, 32'h100, 32'h0, 32'h0, 32'h0,        4'b0000, 32'h0,    32'h0,  32'hDEADBEEF, 32'h0);
    add(4'b0000, 32'h0,   32'h0, 32'h0, 32'h0,        4'b0000, 32'h0,    32'h0,  32'hDEADBEEF, 32'h0);
    // simultaneous DM write / IM read: DM first
    add(4'b0111, 32'h40, 32'h2000, 32'h55AA, 32'h0,   4'b1111, 32'h2000, 32'h55AA, 32'hDEADBEEF, 32'h0);
    add(4'b0111, 32'h40, 32'h2000, 32'h55AA, 32'h0,   4'b1000, 32'h0,    32'h0,  32'hDEADBEEF, 32'h0);
    add(4'b0100, 32'h40, 32'h0, 32'h0, 32'h0,         4'b1010, 32'h40,   32'h0,  32'hDEADBEEF, 32'h0);
    add(4'b0100, 32'h40, 32'h0, 32'h0, 32'hCAFE0040,  4'b1000, 32'h0,    32'h0,  32'hDEADBEEF, 32'h0);
    add(4'b0100, 32'h40, 32'h0, 32'h0, 32'h0,         4'b0000, 32'h0,    32'h0,  32'hCAFE0040, 32'h0);
    add(4'b0000, 32'h0,  32'h0, 32'h0, 32'h0,         4'b0000, 32'h0,    32'h0,  32'hCAFE0040, 32'h0);
    // DM streak: four DM writes while IM waits, then IM is forced through
    for (int k = 0; k < 4; k++) begin
      add(4'b0111, 32'h80, 32'h3000 + k, k + 1, 32'h0, 4'b1111, 32'h3000 + k, k + 1, 32'hCAFE0040, 32'h0);
      add(4'b0111, 32'h80, 32'h3000 + k, k + 1, 32'h0, 4'b1000, 32'h0, 32'h0, 32'hCAFE0040, 32'h0);
    end
    add(4'b0111, 32'h80, 32'h3004, 32'h5, 32'h0,      4'b1110, 32'h80,   32'h0,  32'hCAFE0040, 32'h0);
    add(4'b0111, 32'h80, 32'h3004, 32'h5, 32'h0000BEEF, 4'b1100, 32'h0,  32'h0,  32'hCAFE0040, 32'h0);
    add(4'b0111, 32'h80, 32'h3004, 32'h5, 32'h0,      4'b0100, 32'h0,    32'h0,  32'h0000BEEF, 32'h0);
    // streak cleared: next contention goes to DM
    add(4'b0111, 32'h84, 32'h3004, 32'h5, 32'h0,      4'b1111, 32'h3004, 32'h5,  32'h0000BEEF, 32'h0);
    add(4'b0111, 32'h84, 32'h3004, 32'h5, 32'h0,      4'b1000, 32'h0,    32'h0,  32'h0000BEEF, 32'h0);
    add(4'b0100, 32'h84, 32'h0, 32'h0, 32'h0,         4'b1010, 32'h84,   32'h0,  32'h0000BEEF, 32'h0);
    add(4'b0100, 32'h84, 32'h0, 32'h0, 32'h84848484,  4'b1000, 32'h0,    32'h0,  32'h0000BEEF, 32'h0);
    add(4'b0100, 32'h84, 32'h0, 32'h0, 32'h0,         4'b0000, 32'h0,    32'h0,  32'h84848484, 32'h0);
    add(4'b0000, 32'h0,  32'h0, 32'h0, 32'h0,         4'b0000, 32'h0,    32'h0,  32'h84848484, 32'h0);
    // DM write then DM read of the same address; dm_dout changes only on the read
    add(4'b0011, 32'h0, 32'h500, 32'hA5A5A5A5, 32'h0, 4'b0111, 32'h500, 32'hA5A5A5A5, 32'h84848484, 32'h0);
    add(4'b0011, 32'h0, 32'h500, 32'hA5A5A5A5, 32'h0, 4'b0000, 32'h0,   32'h0,  32'h84848484, 32'h0);
    add(4'b0010, 32'h0, 32'h500, 32'h0, 32'h0,        4'b0110, 32'h500, 32'h0,  32'h84848484, 32'h0);
    add(4'b0010, 32'h0, 32'h500, 32'h0, 32'hA5A5A5A5, 4'b0100, 32'h0,   32'h0,  32'h84848484, 32'h0);
    add(4'b0010, 32'h0, 32'h500, 32'h0, 32'h0,        4'b0000, 32'h0,   32'h0,  32'h84848484, 32'hA5A5A5A5);
    add(4'b0000, 32'h0, 32'h0,   32'h0, 32'h0,        4'b0000, 32'h0,   32'h0,  32'h84848484, 32'hA5A5A5A5);

    for (int i = 0; i < vq.size(); i++) begin
      @(negedge clk);
      rst1           = vq[i].i.f[3];
      if1.im_req_i   = vq[i].i.f[2];
      if1.dm_req_i   = vq[i].i.f[1];
      if1.dm_wen_i   = vq[i].i.f[0];
      if1.im_addr_i  = vq[i].i.im_addr;
      if1.dm_addr_i  = vq[i].i.dm_addr;
      if1.dm_din_i   = vq[i].i.dm_din;
      if1.mem_dout_i = vq[i].i.mem_dout;
      #1;
      chk($sformatf("vec%0d", i), 136'(sample1()), 136'(vq[i].o));
    end

    // RD_LAT=3 DM read
    @(negedge clk); rst3 = 1'b0;
    @(negedge clk);
    if3.dm_req_i = 1'b1; if3.dm_wen_i = 1'b0; if3.dm_addr_i = 32'h300; if3.mem_dout_i = 32'hFFFFFFFF;
    #1;
    chk("lat3_grant", {if3.mem_en_o, if3.mem_wen_o, if3.mem_addr_o, if3.dm_busy_o}, {1'b1, 1'b0, 32'h300, 1'b1});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if3.mem_dout_i = (k == 3) ? 32'h12345678 : 32'hFFFFFFFF;
      #1;
      chk($sformatf("lat3_wait%0d", k), {if3.mem_en_o, if3.dm_busy_o}, 2'b01);
    end
    @(negedge clk); if3.mem_dout_i = 32'hFFFFFFFF; #1;
    chk("lat3_done", {if3.dm_busy_o, if3.dm_dout_o, if3.im_dout_o}, {1'b0, 32'h12345678, 32'h0});
    @(negedge clk); if3.dm_req_i = 1'b0;

    // asynchronous reset during WAIT of an IM read
    @(negedge clk); if3.im_req_i = 1'b1; if3.im_addr_i = 32'h700; #1;
    chk("rst_pre_grant", {if3.mem_en_o, if3.mem_addr_o}, {1'b1, 32'h700});
    @(negedge clk); #1;
    chk("rst_pre_wait", {if3.mem_en_o, if3.im_busy_o}, 2'b01);
    #2 rst3 = 1'b1;
    #1;
    chk("rst_async", {if3.mem_en_o, if3.mem_addr_o, if3.im_busy_o, if3.dm_dout_o, if3.im_dout_o},
        {1'b0, 32'h0, 1'b1, 32'h0, 32'h0});
    @(negedge clk); if3.mem_dout_i = 32'hBADBAD00; #1;
    chk("rst_held", {if3.mem_en_o, if3.im_dout_o}, {1'b0, 32'h0});
    @(negedge clk); rst3 = 1'b0; #1;
    chk("rst_regrant", {if3.mem_en_o, if3.mem_addr_o, if3.im_dout_o}, {1'b1, 32'h700, 32'h0});
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      if3.mem_dout_i = (k == 3) ? 32'h77770700 : 32'hBADBAD00;
      #1;
      chk($sformatf("rst_wait%0d", k), {if3.mem_en_o, if3.im_busy_o, if3.im_dout_o}, {1'b0, 1'b1, 32'h0});
    end
    @(negedge clk); #1;
    chk("rst_done", {if3.im_busy_o, if3.im_dout_o, if3.dm_dout_o}, {1'b0, 32'h77770700, 32'h0});
    @(negedge clk); if3.im_req_i = 1'b0;

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end
endmodule
